// File: rtl/fifo_reader_if.sv
// Handshake bundle between fifo_reader, the FWFT FIFO read port and the wide consumer.
// master = the reader, slave = its environment (FIFO + downstream consumer).
interface fifo_reader_if #(
  parameter int DATA_WIDTH = 2,
  parameter int PACK       = 4,
  parameter int CW         = $clog2(PACK + 1)
);
  logic [DATA_WIDTH-1:0]      fifo_dout;
  logic                       fifo_empty;
  logic                       fifo_pop;
  logic                       flush;
  logic [DATA_WIDTH*PACK-1:0] out_data;
  logic [CW-1:0]              out_count;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    input  fifo_dout, fifo_empty, flush, out_ready,
    output fifo_pop, out_data, out_count, out_valid
  );

  modport slave (
    output fifo_dout, fifo_empty, flush, out_ready,
    input  fifo_pop, out_data, out_count, out_valid
  );
endinterface

// File: rtl/fifo_reader.sv
// Pops narrow words from a first-word-fall-through FIFO and packs PACK of them
// (lane 0 in the LSBs) into one wide word offered on a valid/ready handshake.
module fifo_reader #(
  parameter int DATA_WIDTH = 2,
  parameter int PACK       = 4,
  parameter int CW         = $clog2(PACK + 1)
) (
  input  logic          clk,
  input  logic          reset,
  fifo_reader_if.master bus
);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                     state_r;
  logic [CW-1:0]              cnt_r;
  logic [DATA_WIDTH*PACK-1:0] buf_r;
  logic [CW-1:0]              count_r;
  logic                       valid_r;
  logic                       pop_s;
  logic                       last_lane_s;
  logic [CW-1:0]              pop_inc_s;

  // Pop request: only while filling, out of reset, and with data at the FIFO head.
  always_comb begin
    pop_s = 1'b0;
    if (reset && (state_r == FILL)) begin
      pop_s = !bus.fifo_empty;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Helper terms for the lane counter and the flushed lane count.
  always_comb begin
    last_lane_s = (cnt_r == CW'(PACK - 1));
    pop_inc_s   = {{(CW-1){1'b0}}, pop_s};
  end

  // Packing FSM: lane writes, word completion / flush, handshake and reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= FILL;
      cnt_r   <= {CW{1'b0}};
      buf_r   <= {(DATA_WIDTH*PACK){1'b0}};
      count_r <= {CW{1'b0}};
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (pop_s) begin
            buf_r[cnt_r*DATA_WIDTH +: DATA_WIDTH] <= bus.fifo_dout;
          end
          if (pop_s && last_lane_s) begin
            state_r <= HOLD;
            count_r <= CW'(PACK);
            cnt_r   <= {CW{1'b0}};
            valid_r <= 1'b1;
          end else if (bus.flush && ((cnt_r != {CW{1'b0}}) || pop_s)) begin
            // A word popped in the flush cycle still belongs to the flushed word.
            state_r <= HOLD;
            count_r <= cnt_r + pop_inc_s;
            cnt_r   <= {CW{1'b0}};
            valid_r <= 1'b1;
          end else if (pop_s) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            cnt_r <= cnt_r;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            // Clearing buf here is what makes unused lanes of a flushed word read 0.
            state_r <= FILL;
            buf_r   <= {(DATA_WIDTH*PACK){1'b0}};
            cnt_r   <= {CW{1'b0}};
            valid_r <= 1'b0;
          end else begin
            state_r <= HOLD;
            valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= FILL;
          cnt_r   <= {CW{1'b0}};
          buf_r   <= {(DATA_WIDTH*PACK){1'b0}};
          count_r <= {CW{1'b0}};
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_pop  = pop_s;
  assign bus.out_data  = buf_r;
  assign bus.out_count = count_r;
  assign bus.out_valid = valid_r;

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a directed per-cycle vector table, an idle/flush sequence,
// and randomized traffic from a queue FIFO checked against a lane-list model.
module tb_fifo_reader;

  localparam int DW = 2;
  localparam int PK = 4;
  localparam int CW = $clog2(PK + 1);

  logic clk;
  logic reset;

  fifo_reader_if #(.DATA_WIDTH(DW), .PACK(PK), .CW(CW)) bus ();

  fifo_reader #(.DATA_WIDTH(DW), .PACK(PK), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       emp;
    logic [1:0] d;
    logic       fl;
    logic       rdy;
    logic       pop;
    logic       val;
    logic [7:0] data;
    logic [2:0] cnt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rst, input logic emp, input logic [1:0] d, input logic fl,
                     input logic rdy, input logic pop, input logic val, input logic [7:0] data,
                     input logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.emp = emp; v.d = d; v.fl = fl; v.rdy = rdy;
    v.pop = pop; v.val = val; v.data = data; v.cnt = cnt;
    tv.push_back(v);
  endtask

  // Higher-level reference: popped words collect in a list; a word closes at PACK or on flush.
  logic [1:0] lanes[$];
  logic       holding;
  logic [7:0] pend_data;
  logic [2:0] pend_cnt;
  logic [1:0] q[$];

  function automatic logic [7:0] pack_lanes();
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < lanes.size(); i++) r = r | (8'(lanes[i]) << (i * DW));
    return r;
  endfunction

  initial begin
    logic exp_pop;
    logic cur_rst;
    logic cur_fl;
    logic cur_rdy;
    logic [1:0] cur_d;

    reset = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = 2'd0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge clk);

    //   rst emp d   fl rdy | pop val data   cnt
    add(0, 0, 2'd1, 0, 1,   0, 0, 8'h00, 3'd0);   // reset forces pop low
    add(1, 0, 2'd1, 0, 1,   1, 0, 8'h00, 3'd0);
    add(1, 0, 2'd2, 0, 1,   1, 0, 8'h01, 3'd0);
    add(1, 0, 2'd3, 0, 1,   1, 0, 8'h09, 3'd0);
    add(1, 0, 2'd0, 0, 1,   1, 0, 8'h39, 3'd0);
    add(1, 1, 2'd0, 0, 0,   0, 1, 8'h39, 3'd4);   // backpressure
    add(1, 0, 2'd1, 0, 0,   0, 1, 8'h39, 3'd4);
    add(1, 0, 2'd1, 0, 0,   0, 1, 8'h39, 3'd4);
    add(1, 0, 2'd1, 0, 0,   0, 1, 8'h39, 3'd4);
    add(1, 0, 2'd1, 0, 0,   0, 1, 8'h39, 3'd4);
    add(1, 1, 2'd0, 0, 1,   0, 1, 8'h39, 3'd4);   // accepted here
    add(1, 1, 2'd0, 0, 1,   0, 0, 8'h00, 3'd0);
    add(1, 0, 2'd1, 0, 1,   1, 0, 8'h00, 3'd0);   // flush of 2 lanes
    add(1, 0, 2'd2, 0, 1,   1, 0, 8'h01, 3'd0);
    add(1, 1, 2'd0, 0, 1,   0, 0, 8'h09, 3'd0);
    add(1, 1, 2'd0, 1, 1,   0, 0, 8'h09, 3'd0);
    add(1, 1, 2'd0, 1, 0,   0, 1, 8'h09, 3'd2);   // flush ignored in HOLD
    add(1, 1, 2'd0, 0, 1,   0, 1, 8'h09, 3'd2);
    add(1, 1, 2'd0, 1, 1,   0, 0, 8'h00, 3'd0);   // empty flush ignored
    add(1, 1, 2'd0, 0, 1,   0, 0, 8'h00, 3'd0);
    add(1, 0, 2'd1, 0, 1,   1, 0, 8'h00, 3'd0);   // flush with pop
    add(1, 0, 2'd2, 0, 1,   1, 0, 8'h01, 3'd0);
    add(1, 0, 2'd3, 1, 1,   1, 0, 8'h09, 3'd0);
    add(1, 1, 2'd0, 0, 1,   0, 1, 8'h39, 3'd3);
    add(1, 1, 2'd0, 0, 1,   0, 0, 8'h00, 3'd0);
    add(1, 0, 2'd1, 0, 1,   1, 0, 8'h00, 3'd0);   // reset mid-fill
    add(1, 0, 2'd2, 0, 1,   1, 0, 8'h01, 3'd0);
    add(0, 0, 2'd3, 0, 1,   0, 0, 8'h09, 3'd0);
    add(1, 0, 2'd3, 0, 1,   1, 0, 8'h00, 3'd0);
    add(1, 0, 2'd3, 0, 1,   1, 0, 8'h03, 3'd0);
    add(1, 0, 2'd3, 0, 1,   1, 0, 8'h0F, 3'd0);
    add(1, 0, 2'd3, 0, 1,   1, 0, 8'h3F, 3'd0);
    add(1, 1, 2'd0, 0, 1,   0, 1, 8'hFF, 3'd4);
    add(1, 1, 2'd0, 0, 1,   0, 0, 8'h00, 3'd0);

    foreach (tv[i]) begin
      @(negedge clk);
      reset          = tv[i].rst;
      bus.fifo_empty = tv[i].emp;
      bus.fifo_dout  = tv[i].d;
      bus.flush      = tv[i].fl;
      bus.out_ready  = tv[i].rdy;
      #1;
      chk($sformatf("vec%0d_pop", i), 32'(bus.fifo_pop), 32'(tv[i].pop));
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(tv[i].val));
      chk($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(tv[i].data));
      if (tv[i].val) chk($sformatf("vec%0d_count", i), 32'(bus.out_count), 32'(tv[i].cnt));
    end

    // Empty idle with flush toggling: nothing may be popped or emitted.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      reset          = 1'b1;
      bus.fifo_empty = 1'b1;
      bus.fifo_dout  = 2'(i);
      bus.flush      = i[0];
      bus.out_ready  = 1'b1;
      #1;
      chk("idle_pop", 32'(bus.fifo_pop), 32'd0);
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
    end

    // Randomized traffic; the first cycle is a reset that syncs the model.
    lanes.delete();
    q.delete();
    holding = 1'b0;
    pend_data = 8'h00;
    pend_cnt = 3'd0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 1) == 0) q.push_back(2'($urandom));
      cur_rst = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      cur_fl  = ($urandom_range(0, 9) == 0);
      cur_rdy = ($urandom_range(0, 9) < 6);
      cur_d   = (q.size() > 0) ? q[0] : 2'($urandom);
      reset          = cur_rst;
      bus.fifo_empty = (q.size() == 0);
      bus.fifo_dout  = cur_d;
      bus.flush      = cur_fl;
      bus.out_ready  = cur_rdy;
      #1;
      exp_pop = cur_rst && !holding && (q.size() > 0);
      chk("rnd_pop", 32'(bus.fifo_pop), 32'(exp_pop));
      if (c > 0) begin
        chk("rnd_valid", 32'(bus.out_valid), 32'(holding));
        if (holding) begin
          chk("rnd_data", 32'(bus.out_data), 32'(pend_data));
          chk("rnd_count", 32'(bus.out_count), 32'(pend_cnt));
        end else begin
          chk("rnd_fill_data", 32'(bus.out_data), 32'(pack_lanes()));
        end
      end
      @(posedge clk);
      #1;
      if (!cur_rst) begin
        lanes.delete();
        holding = 1'b0;
      end else if (holding) begin
        if (cur_rdy) holding = 1'b0;
      end else begin
        if (exp_pop) lanes.push_back(cur_d);
        if ((lanes.size() == PK) || (cur_fl && (lanes.size() > 0))) begin
          pend_data = pack_lanes();
          pend_cnt  = 3'(lanes.size());
          holding   = 1'b1;
          lanes.delete();
        end
      end
      if (exp_pop) void'(q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
